// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The enum replaces the old IfIdle/IfFetch/IfHold/IfDiscard encodings.
package if_fetch_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;
  localparam int PC_STEP     = 4;

  localparam logic [INST_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    IF_IDLE    = 2'd0,
    IF_FETCH   = 2'd1,
    IF_HOLD    = 2'd2,
    IF_DISCARD = 2'd3
  } if_state_e;

endpackage

// File: rtl/if_fetch_next_pc.sv
// Next-PC selection for the fetch stage.
// A live branch wins over a remembered one, which wins over sequential +4.
import if_fetch_pkg::*;

module if_fetch_next_pc #(
  parameter int ADDR_W = INST_ADDR_W
) (
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              pend_br_i,
  input  logic [ADDR_W-1:0] pend_tgt_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic [ADDR_W-1:0] next_pc_o
);

  always_comb begin
    // Sequential step wraps naturally at the top of the address space.
    next_pc_o = pc_i + ADDR_W'(PC_STEP);
    if (pend_br_i) begin
      next_pc_o = pend_tgt_i;
    end
    if (branch_flag_i) begin
      next_pc_o = branch_target_i;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives the req/ack instruction bus,
// buffers a word across IF stalls and remembers branches that arrive mid-fetch.
import if_fetch_pkg::*;

module if_fetch #(
  parameter int                ADDR_W   = INST_ADDR_W,
  parameter int                DATA_W   = INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_address_i,
  output logic              inst_req_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  input  logic              inst_ack_i,
  input  logic [DATA_W-1:0] inst_rdata_i,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_inst,
  output logic              stallreq_from_if
);

  if_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] inst_buf_q, inst_buf_d;
  logic              pend_br_q, pend_br_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;

  logic              done;
  logic              advance;
  logic [ADDR_W-1:0] next_pc;

  // Only bit 0 of the ctrl stall vector concerns the PC.
  logic unused_stall;
  assign unused_stall = ^stall[5:1];

  assign done    = ((state_q == IF_FETCH) && inst_ack_i) || (state_q == IF_HOLD);
  assign advance = done && !stall[0];

  if_fetch_next_pc #(
    .ADDR_W(ADDR_W)
  ) u_next_pc (
    .branch_flag_i  (branch_flag_i),
    .branch_target_i(branch_target_address_i),
    .pend_br_i      (pend_br_q),
    .pend_tgt_i     (pend_tgt_q),
    .pc_i           (pc_q),
    .next_pc_o      (next_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IF_IDLE;
      pc_q       <= RESET_PC;
      inst_buf_q <= '0;
      pend_br_q  <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_buf_q <= inst_buf_d;
      pend_br_q  <= pend_br_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_buf_d = inst_buf_q;
    pend_br_d  = pend_br_q;
    pend_tgt_d = pend_tgt_q;

    if (flush) begin
      pc_d       = new_pc;
      pend_br_d  = 1'b0;
      inst_buf_d = '0;
      // An unacked request is still owed an ack; swallow it before refetching.
      if (((state_q == IF_FETCH) || (state_q == IF_DISCARD)) && !inst_ack_i) begin
        state_d = IF_DISCARD;
      end else begin
        state_d = IF_FETCH;
      end
    end else begin
      case (state_q)
        IF_IDLE: state_d = IF_FETCH;
        IF_FETCH: begin
          if (inst_ack_i) begin
            if (stall[0]) begin
              state_d    = IF_HOLD;
              inst_buf_d = inst_rdata_i;
            end else begin
              state_d = IF_FETCH;
            end
          end
        end
        IF_HOLD: begin
          if (!stall[0]) begin
            state_d = IF_FETCH;
          end
        end
        IF_DISCARD: begin
          if (inst_ack_i) begin
            state_d = IF_FETCH;
          end
        end
        default: state_d = IF_IDLE;
      endcase

      if (advance) begin
        pc_d      = next_pc;
        pend_br_d = 1'b0;
      end else if (branch_flag_i) begin
        // Branch leaves ID while IF is busy with the delay slot: keep it.
        pend_br_d  = 1'b1;
        pend_tgt_d = branch_target_address_i;
      end
    end
  end

  always_comb begin
    inst_req_o       = (state_q == IF_FETCH) || (state_q == IF_DISCARD);
    inst_addr_o      = pc_q;
    if_pc            = pc_q;
    if_inst          = '0;
    stallreq_from_if = ((state_q == IF_FETCH) && !inst_ack_i) || (state_q == IF_DISCARD);
    if (state_q == IF_HOLD) begin
      if_inst = inst_buf_q;
    end else if ((state_q == IF_FETCH) && inst_ack_i) begin
      if_inst = inst_rdata_i;
    end
  end

endmodule
